noc_arbiter: RTL and testbench

NOC_ARBITER -- requirements
Module: noc_arbiter

---
 rtl/noc_arbiter.sv | 168 ++++++++++++++++
 tb/tb_noc_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_arbiter.sv
// Round-robin arbiter funnelling N_CPU request streams into one NOC port,
// with per-CPU outstanding credit tracking and a combinational response demux.
module noc_arbiter #(
    parameter int N_CPU   = 4,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4,
    parameter int IDX_W   = $clog2(N_CPU)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CPU-1:0]        cpu_vld,
    output logic [N_CPU-1:0]        cpu_rdy,
    input  logic [N_CPU*DATA_W-1:0] cpu_data,
    output logic                    noc_vld,
    input  logic                    noc_rdy,
    output logic [DATA_W-1:0]       noc_data,
    output logic [IDX_W-1:0]        noc_idx,
    input  logic                    resp_vld,
    output logic                    resp_rdy,
    input  logic [DATA_W-1:0]       resp_data,
    input  logic [IDX_W-1:0]        resp_idx,
    output logic [N_CPU-1:0]        cpu_resp_vld,
    input  logic [N_CPU-1:0]        cpu_resp_rdy,
    output logic [DATA_W-1:0]       cpu_resp_data,
    output logic                    err_bad_idx
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [7:0]     MAX_O = 8'(MAX_OUT);
    localparam logic [IDX_W:0] NC    = (IDX_W + 1)'(N_CPU);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr;
    logic [7:0]            outstanding [N_CPU];
    logic [N_CPU-1:0]      elig;
    logic [2*N_CPU-1:0]    dbl;
    logic [N_CPU-1:0]      rot;
    logic [IDX_W-1:0]      off;
    logic [IDX_W:0]        sum;
    logic [IDX_W-1:0]      win;
    logic                  found;
    logic                  grant;
    logic [DATA_W-1:0]     win_data;
    logic [N_CPU-1:0]      resp_dec;
    logic                  resp_hit;
    logic                  resp_bad;
    logic                  underflow;

    // Eligibility is rotated so that bit 0 corresponds to ptr.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CPU; i++) begin
            elig[i] = cpu_vld[i] && (outstanding[i] < MAX_O);
        end
        dbl   = {elig, elig} >> ptr;
        rot   = dbl[N_CPU-1:0];
        found = |rot;
        off   = '0;
        for (int i = N_CPU - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NC) begin
            sum = sum - NC;
        end
        win = sum[IDX_W-1:0];
    end

    assign grant = found && ((state_q == EMPTY) || noc_rdy);

    always_comb begin
        cpu_rdy  = '0;
        win_data = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (win == IDX_W'(i)) begin
                cpu_rdy[i] = grant;
                win_data   = cpu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (grant) begin
            state_d = FULL;
        end else if (state_q == FULL && noc_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign noc_vld = (state_q == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noc_data <= '0;
            noc_idx  <= '0;
            ptr      <= '0;
        end else if (grant) begin
            noc_data <= win_data;
            noc_idx  <= win;
            ptr      <= (win == IDX_W'(N_CPU - 1)) ? '0 : win + 1'b1;
        end
    end

    // Out-of-range indices match no CPU and are accepted unconditionally.
    always_comb begin
        cpu_resp_vld = '0;
        resp_rdy     = 1'b1;
        resp_hit     = 1'b0;
        for (int i = 0; i < N_CPU; i++) begin
            if (resp_idx == IDX_W'(i)) begin
                cpu_resp_vld[i] = resp_vld;
                resp_rdy        = cpu_resp_rdy[i];
                resp_hit        = 1'b1;
            end
        end
    end

    assign cpu_resp_data = resp_data;
    assign resp_bad      = resp_vld && !resp_hit;

    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < N_CPU; i++) begin
            resp_dec[i] = cpu_resp_vld[i] && cpu_resp_rdy[i];
            if (resp_dec[i] && outstanding[i] == 8'd0) begin
                underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CPU; i++) begin
                outstanding[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_CPU; i++) begin
                if (cpu_rdy[i] && cpu_vld[i] && !resp_dec[i]) begin
                    outstanding[i] <= outstanding[i] + 8'd1;
                end else if (resp_dec[i] && !(cpu_rdy[i] && cpu_vld[i])
                             && outstanding[i] != 8'd0) begin
                    outstanding[i] <= outstanding[i] - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bad_idx <= 1'b0;
        end else if (resp_bad || underflow) begin
            err_bad_idx <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_arbiter.sv
// Scoreboard bench for noc_arbiter: a reference model predicts grants,
// queues expected NOC requests and compares them as the DUT emits them.
module tb_noc_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    cpu_vld = '0;
    logic [N-1:0]    cpu_rdy;
    logic [N*DW-1:0] cpu_data = '0;
    logic            noc_vld;
    logic            noc_rdy = 1'b0;
    logic [DW-1:0]   noc_data;
    logic [IW-1:0]   noc_idx;
    logic            resp_vld = 1'b0;
    logic            resp_rdy;
    logic [DW-1:0]   resp_data = '0;
    logic [IW-1:0]   resp_idx = '0;
    logic [N-1:0]    cpu_resp_vld;
    logic [N-1:0]    cpu_resp_rdy = '1;
    logic [DW-1:0]   cpu_resp_data;
    logic            err_bad_idx;

    noc_arbiter #(.N_CPU(N), .DATA_W(DW), .MAX_OUT(4), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_vld(cpu_vld), .cpu_rdy(cpu_rdy), .cpu_data(cpu_data),
        .noc_vld(noc_vld), .noc_rdy(noc_rdy), .noc_data(noc_data),
        .noc_idx(noc_idx),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .resp_idx(resp_idx),
        .cpu_resp_vld(cpu_resp_vld), .cpu_resp_rdy(cpu_resp_rdy),
        .cpu_resp_data(cpu_resp_data),
        .err_bad_idx(err_bad_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [63:0] d;
    } req_t;

    int     checks = 0;
    int     errors = 0;
    int     m_ptr = 0;
    int     m_out [N];
    bit     m_full = 0;
    bit     m_err = 0;
    bit     auto_rsp = 0;
    logic [N-1:0] rsp_mask = '1;
    req_t   sb [$];
    int     resp_q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < N; i++) begin
            cpu_data[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_err  = 0;
        for (int i = 0; i < N; i++) m_out[i] = 0;
        sb.delete();
        resp_q.delete();
    endtask

    task automatic cycle();
        int           w;
        int           j;
        int           ri;
        int           dec_i;
        bit           can;
        bit           exp_rr;
        bit           inc;
        bit           dec;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_crv;
        req_t         it;
        @(negedge clk);
        chk("err_bad_idx", err_bad_idx, m_err);
        chk("noc_vld", noc_vld, m_full);
        if (m_full) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                chk("noc_idx", noc_idx, sb[0].idx);
                chk("noc_data", noc_data, sb[0].d);
            end
        end
        can = !m_full || noc_rdy;
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (w < 0 && cpu_vld[j] && m_out[j] < 4) w = j;
        end
        exp_rdy = '0;
        if (can && w >= 0) exp_rdy[w] = 1'b1;
        chk("cpu_rdy", cpu_rdy, exp_rdy);
        exp_rr = 0;
        dec_i  = -1;
        if (resp_vld) begin
            ri      = int'(resp_idx);
            exp_rr  = (ri < N) ? cpu_resp_rdy[ri] : 1'b1;
            exp_crv = '0;
            if (ri < N) exp_crv[ri] = 1'b1;
            chk("resp_rdy", resp_rdy, exp_rr);
            chk("cpu_resp_vld", cpu_resp_vld, exp_crv);
            chk("cpu_resp_data", cpu_resp_data, resp_data);
        end else begin
            chk("cpu_resp_vld_idle", cpu_resp_vld, 0);
        end
        if (m_full && noc_rdy && sb.size() > 0) begin
            it = sb.pop_front();
            if (rsp_mask[it.idx]) resp_q.push_back(it.idx);
        end
        if (resp_vld && exp_rr) begin
            if (auto_rsp && resp_q.size() > 0) void'(resp_q.pop_front());
            if (ri >= N) m_err = 1;
            else dec_i = ri;
        end
        for (int i = 0; i < N; i++) begin
            inc = exp_rdy[i];
            dec = (i == dec_i);
            if (dec && m_out[i] == 0) m_err = 1;
            if (inc && !dec) m_out[i]++;
            else if (dec && !inc && m_out[i] > 0) m_out[i]--;
        end
        if (can && w >= 0) begin
            it.idx = w;
            it.d   = 64'(cpu_data >> (w * DW));
            sb.push_back(it);
            m_ptr  = (w + 1) % N;
            m_full = 1;
        end else if (m_full && noc_rdy) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            if (resp_q.size() > 0) begin
                resp_vld  = 1'b1;
                resp_idx  = IW'(resp_q[0]);
                resp_data = {$urandom, $urandom};
            end else begin
                resp_vld = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_noc_vld", noc_vld, 0);
        chk("rst_noc_data", noc_data, 0);
        chk("rst_noc_idx", noc_idx, 0);
        chk("rst_err", err_bad_idx, 0);
        chk("rst_cpu_rdy", cpu_rdy, 0);
        rst_n = 1'b1;

        // Saturated round robin with immediate responses
        auto_rsp = 1;
        rsp_mask = '1;
        cpu_vld  = '1;
        noc_rdy  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            new_data();
            cycle();
        end
        cpu_vld = '0;
        run(8);

        // Single CPU held under back-pressure
        cpu_data[2*DW +: DW] = 64'hDEADBEEFDEADBEEF;
        cpu_vld = 4'b0100;
        noc_rdy = 1'b0;
        run(6);
        noc_rdy = 1'b1;
        cycle();
        cpu_vld = '0;
        run(6);

        // CPU 1 credit exhaustion while CPU 3 keeps flowing
        rsp_mask = 4'b1000;
        cpu_vld  = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            new_data();
            cycle();
        end
        auto_rsp     = 0;
        resp_q.delete();
        cpu_vld      = 4'b0010;
        resp_vld     = 1'b1;
        resp_idx     = 3'd1;
        cpu_resp_rdy = 4'b1101;
        cycle();
        cpu_resp_rdy = '1;
        cycle();
        resp_vld = 1'b0;
        run(4);

        // Simultaneous request and response on CPU 0
        cpu_vld = 4'b0001;
        run(2);
        resp_vld = 1'b1;
        resp_idx = 3'd0;
        cycle();
        resp_vld = 1'b0;
        run(4);

        // Out-of-range response index
        cpu_vld  = '0;
        resp_vld = 1'b1;
        resp_idx = 3'd5;
        cycle();
        resp_vld = 1'b0;
        run(3);

        // Asynchronous reset while holding a request
        cpu_vld = 4'b1100;
        noc_rdy = 1'b0;
        run(2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_noc_vld", noc_vld, 0);
        chk("arst_noc_data", noc_data, 0);
        chk("arst_noc_idx", noc_idx, 0);
        chk("arst_err", err_bad_idx, 0);
        model_reset();
        #1 rst_n = 1'b1;
        noc_rdy = 1'b1;
        run(5);

        // Response to a CPU with no outstanding requests
        cpu_vld  = '0;
        run(3);
        resp_vld = 1'b1;
        resp_idx = 3'd1;
        cycle();
        resp_vld = 1'b0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
